// File: rtl/pc_redirect_if.sv
// Redirect request / PC-source control bundle between the hazard, branch and exception units and the IF stage.
// The PC_REDIRECT_PERF_EN macro adds the performance counter signals.
interface pc_redirect_if
`ifdef PC_REDIRECT_PERF_EN
  #(parameter int unsigned CNT_W = 16)
`endif
  ;
  logic       stall;
  logic       xadr_req;
  logic       illop_req;
  logic       jr_req;
  logic       jt_req;
  logic       bt_req;
  logic [2:0] pc_src_sel;
  logic       pc_write;
  logic       flush_if;
  logic       flush_id;
  logic       exc_active;
  logic       pending;
`ifdef PC_REDIRECT_PERF_EN
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] exc_cnt;
`endif

  modport master (
    output stall, xadr_req, illop_req, jr_req, jt_req, bt_req,
    input  pc_src_sel, pc_write, flush_if, flush_id, exc_active, pending
`ifdef PC_REDIRECT_PERF_EN
    , input redirect_cnt, exc_cnt
`endif
  );

  modport slave (
    input  stall, xadr_req, illop_req, jr_req, jt_req, bt_req,
    output pc_src_sel, pc_write, flush_if, flush_id, exc_active, pending
`ifdef PC_REDIRECT_PERF_EN
    , output redirect_cnt, exc_cnt
`endif
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC-source redirect arbiter with stall-time redirect hold/replay and a post-exception flush window.
// Define PC_REDIRECT_PERF_EN to add saturating redirect/exception counters.
module pc_redirect_ctrl #(
  parameter int unsigned EXC_FLUSH = 2
`ifdef PC_REDIRECT_PERF_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_redirect_if.slave bus
);

  localparam int unsigned SW  = 3;
  localparam int unsigned FCW = $clog2(EXC_FLUSH + 1);

  // Source codes are ordered so that a larger code means higher priority.
  localparam logic [SW-1:0] SEL_PLUS4 = 3'd0;
  localparam logic [SW-1:0] SEL_BT    = 3'd1;
  localparam logic [SW-1:0] SEL_JT    = 3'd2;
  localparam logic [SW-1:0] SEL_JR    = 3'd3;
  localparam logic [SW-1:0] SEL_ILLOP = 3'd4;
  localparam logic [SW-1:0] SEL_XADR  = 3'd5;

  typedef enum logic {IDLE, EXC} state_e;

  state_e         state_q, state_d;
  logic [SW-1:0]  held_q, held_d;
  logic [FCW-1:0] cnt_q, cnt_d;

  logic           in_exc;
  logic [SW-1:0]  new_src;
  logic [SW-1:0]  winner;
  logic [SW-1:0]  sel_c;
  logic           flush_if_c;
  logic           flush_id_c;

`ifdef PC_REDIRECT_PERF_EN
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic [CNT_W-1:0] exc_cnt_q, exc_cnt_d;
`endif

  assign in_exc = (state_q == EXC);

  // Highest new request; wrong-path and illegal-op requests are masked during the flush window.
  always_comb begin
    new_src = SEL_PLUS4;
    if (bus.xadr_req)                  new_src = SEL_XADR;
    else if (bus.illop_req && !in_exc) new_src = SEL_ILLOP;
    else if (bus.jr_req && !in_exc)    new_src = SEL_JR;
    else if (bus.jt_req && !in_exc)    new_src = SEL_JT;
    else if (bus.bt_req && !in_exc)    new_src = SEL_BT;
    winner = (held_q > new_src) ? held_q : new_src;
  end

  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    cnt_d      = cnt_q;
    sel_c      = SEL_PLUS4;
    flush_if_c = 1'b0;
    flush_id_c = in_exc;
`ifdef PC_REDIRECT_PERF_EN
    redirect_cnt_d = redirect_cnt_q;
    exc_cnt_d      = exc_cnt_q;
`endif
    if (bus.stall) begin
      held_d = winner;
    end else begin
      held_d     = SEL_PLUS4;
      sel_c      = winner;
      flush_if_c = (winner != SEL_PLUS4);
      if (winner >= SEL_ILLOP) begin
        flush_id_c = 1'b1;
        state_d    = EXC;
        cnt_d      = FCW'(EXC_FLUSH);
      end else if (in_exc) begin
        cnt_d = cnt_q - FCW'(1);
        if (cnt_q <= FCW'(1)) state_d = IDLE;
      end
`ifdef PC_REDIRECT_PERF_EN
      if (winner != SEL_PLUS4 && redirect_cnt_q != '1) redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
      if (winner >= SEL_ILLOP && exc_cnt_q != '1)      exc_cnt_d      = exc_cnt_q + CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      held_q  <= SEL_PLUS4;
      cnt_q   <= '0;
`ifdef PC_REDIRECT_PERF_EN
      redirect_cnt_q <= '0;
      exc_cnt_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
`ifdef PC_REDIRECT_PERF_EN
      redirect_cnt_q <= redirect_cnt_d;
      exc_cnt_q      <= exc_cnt_d;
`endif
    end
  end

  // Zero-latency outputs, forced to their idle values while reset is asserted.
  assign bus.pc_src_sel = rst_n ? sel_c : SEL_PLUS4;
  assign bus.pc_write   = rst_n & ~bus.stall;
  assign bus.flush_if   = rst_n & flush_if_c;
  assign bus.flush_id   = rst_n & flush_id_c;
  assign bus.exc_active = rst_n & in_exc;
  assign bus.pending    = rst_n & (held_q != SEL_PLUS4);
`ifdef PC_REDIRECT_PERF_EN
  assign bus.redirect_cnt = redirect_cnt_q;
  assign bus.exc_cnt      = exc_cnt_q;
`endif

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequences the PC-source mux: arbitrates redirect requests from exception logic, the decoder, and the branch unit, and drives the 3-bit PC-source select plus the PC write enable.
- Holds a redirect that arrives during a pipeline stall and replays it on the first unstalled cycle.
- Runs a fixed-length flush window after exceptions.
- Sits between the hazard/branch/exception units and the PC register in the IF stage.

Parameters:
- EXC_FLUSH, 2, number of cycles the exception flush window lasts (≥1).
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard stall: PC must not update this cycle.
- xadr_req  in  1  external interrupt/exception redirect request.
- illop_req  in  1  illegal-opcode redirect request.
- jr_req  in  1  jump-register redirect request.
- jt_req  in  1  jump-target redirect request.
- bt_req  in  1  taken-branch redirect request.
- pc_src_sel  out  3  PC-source select.
- pc_write  out  1  PC register write enable.
- flush_if  out  1  squash the IF/ID register.
- flush_id  out  1  squash the ID/EX register.
- exc_active  out  1  exception flush window in progress.
- pending  out  1  a held redirect is waiting for the stall to clear.

Behaviour:
- Select encodings: PLUS4=3'd0, BT=3'd1, JT=3'd2, JR=3'd3, ILLOP=3'd4, XADR=3'd5. Codes 6–7 are never driven.
- Priority, highest first: XADR, ILLOP, JR, JT, BT, PLUS4.
- "Accepted" means the winning source is driven with pc_write=1.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, pending register cleared, flush counter=0.
  - Outputs: pc_src_sel=PLUS4, pc_write=0, flush_if=0, flush_id=0, exc_active=0, pending=0.
- Outputs are combinational from the current inputs and registered state: a request is accepted with 0 latency in the cycle it is presented.
- pc_write = ~stall whenever out of reset.
- Unstalled cycle:
  - Winner is the higher-priority of (held pending source, new requests).
  - pc_src_sel = winner. Pending is cleared at the clock edge.
  - If winner ≠ PLUS4: flush_if=1.
  - If winner is XADR or ILLOP: also flush_id=1.
- Stalled cycle:
  - pc_src_sel=PLUS4 (don't-care because pc_write=0); flushes stay 0.
  - The highest new request is compared with the held source. The higher of the two is stored at the edge and pending=1.
  - A lower-priority new request is dropped.
- States: IDLE, EXC.
  - IDLE→EXC on an accepted XADR/ILLOP; counter loaded with EXC_FLUSH.
  - In EXC: exc_active=1.
  - flush_id=1 every cycle, including stalled cycles.
  - jr/jt/bt requests are ignored (wrong path) and are not captured into pending.
  - illop_req is ignored.
  - xadr_req is still accepted and reloads the counter to EXC_FLUSH.
  - The counter decrements on each unstalled cycle; EXC→IDLE when it reaches 1 and decrements.
- Simultaneous events:
  - xadr_req with a held BT pending when the stall clears: XADR wins and the held BT is discarded.
  - A held XADR/ILLOP replayed on leaving the stall enters EXC exactly like a direct acceptance.
- Reset mid-operation aborts EXC and pending immediately (asynchronous). No request is replayed after reset.

Optional Feature:
- Macro PC_REDIRECT_PERF_EN.
- Defined:
  - Output redirect_cnt[CNT_W-1:0] increments on each accepted non-PLUS4 redirect.
  - Output exc_cnt[CNT_W-1:0] increments on each accepted XADR/ILLOP.
  - Both saturate at all-ones and reset to 0.
- Undefined: neither counter exists, no extra ports; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 → pc_write=0, pc_src_sel=0, pending=0. Release with no requests → pc_write=1, sel=0 every cycle.
- Direct branch: stall=0, bt_req=1 for 1 cycle → same cycle sel=1, pc_write=1, flush_if=1, flush_id=0. Next cycle sel=0.
- Stall capture: stall=1 for 3 cycles with jt_req pulse in cycle 1 and bt_req pulse in cycle 2 → pending=1, sel held internally as JT. First cycle with stall=0 → sel=2, flush_if=1, pending=0.
- Priority override: while stalled, bt_req captured, then jr_req pulse → the stall releases with sel=3. Simultaneous xadr_req+jr_req unstalled → sel=5.
- Exception window (EXC_FLUSH=2): illop_req unstalled → sel=4, flush_if=1, flush_id=1, exc_active=1 for exactly 2 unstalled cycles. A jr_req during the window → sel stays 0. An xadr_req in window cycle 2 → sel=5 and the window is extended by 2.
- Async reset mid-EXC with a BT pending → all outputs return to reset values immediately. After release: exc_active=0, no replay. With PC_REDIRECT_PERF_EN, the counters read 0.
